// File: rtl/demux_sipo_collector.sv
// Serial-to-parallel collector: routes accepted bits into successive word positions
// selected by an internal counter, with a one-word output buffer toward the consumer.

module demux_sipo_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic clr,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (wr)  q <= d;
  end
endmodule

module demux_sipo_collector #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  parameter int ORDER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [SEL_W-1:0] sel_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready
);
  localparam logic [SEL_W-1:0] FIRST = (ORDER == 0) ? '0 : SEL_W'(WIDTH-1);
  localparam logic [SEL_W-1:0] LAST  = (ORDER == 0) ? SEL_W'(WIDTH-1) : '0;

  typedef enum logic {EMPTY, HELD} buf_t;
  buf_t state, state_nxt;

  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] shadow, cap;
  logic             at_last, acc, done, load;

  assign sel_out    = sel_q;
  assign word_valid = (state == HELD);
  assign at_last    = (sel_q == LAST);
  // Only the closing bit must wait for the buffer; earlier bits fill the shadow freely.
  assign bit_ready  = !flush && !(at_last && word_valid && !word_ready);
  assign acc        = bit_valid && bit_ready;
  assign done       = acc && at_last;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    demux_sipo_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (acc && (sel_q == SEL_W'(i))),
      .clr   (flush),
      .d     (bit_in),
      .q     (shadow[i])
    );
  end

  // Closing bit bypasses the shadow so the word is complete on the same edge.
  always_comb begin
    cap       = shadow;
    cap[LAST] = bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sel_q <= FIRST;
    else if (flush) sel_q <= FIRST;
    else if (acc) begin
      if (at_last)         sel_q <= FIRST;
      else if (ORDER == 0) sel_q <= sel_q + 1'b1;
      else                 sel_q <= sel_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: if (done) begin
        state_nxt = HELD;
        load      = 1'b1;
      end
      HELD: begin
        if (done) load = 1'b1;
        else if (word_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    word_out <= '0;
    else if (load) word_out <= cap;
  end
endmodule
